// File: rtl/mig_ui_responder_if.sv
// MIG user-interface bundle between an app-side master and the responder (slave).
// Carries command, write-data and read-return channels plus calibration/error status.
interface mig_ui_responder_if #(
  parameter int DATA_W = 128
);
  logic              init_calib_complete;
  logic              app_rdy;
  logic              app_wdf_rdy;
  logic              app_en;
  logic [2:0]        app_cmd;
  logic [27:0]       app_addr;
  logic              app_wdf_wren;
  logic              app_wdf_end;
  logic [DATA_W-1:0] app_wdf_data;
  logic [DATA_W-1:0] app_rd_data;
  logic              app_rd_data_valid;
  logic              app_rd_data_end;
  logic              err_cmd;

  modport master (
    output app_en, app_cmd, app_addr, app_wdf_wren, app_wdf_end, app_wdf_data,
    input  init_calib_complete, app_rdy, app_wdf_rdy, app_rd_data,
           app_rd_data_valid, app_rd_data_end, err_cmd
  );

  modport slave (
    input  app_en, app_cmd, app_addr, app_wdf_wren, app_wdf_end, app_wdf_data,
    output init_calib_complete, app_rdy, app_wdf_rdy, app_rd_data,
           app_rd_data_valid, app_rd_data_end, err_cmd
  );
endinterface

// File: rtl/mig_ui_responder.sv
// MIG UI responder: 4-deep cmd/data FIFOs, in-order retire into a backing store, read data RD_LAT cycles after retire.
// Backpressure only via app_rdy/app_wdf_rdy on FIFO full; MIG_RESP_THROTTLE_EN adds LFSR ready throttling.
module mig_ui_responder #(
  parameter int DATA_W       = 128,
  parameter int MEM_AW       = 10,
  parameter int RD_LAT       = 4,
  parameter int CALIB_CYCLES = 64
) (
  input  logic                ui_clk,
  input  logic                rst_n,
  mig_ui_responder_if.slave   ui
);

  localparam int CW = $clog2(CALIB_CYCLES) + 1;
  localparam logic [CW-1:0] CAL_LAST = CW'(CALIB_CYCLES - 1);

  // calibration emulation
  logic [CW-1:0] r_cal_cnt;
  logic          r_calib;

  always_ff @(posedge ui_clk) begin
    if (!rst_n) begin
      r_cal_cnt <= '0;
      r_calib   <= 1'b0;
    end else if (!r_calib) begin
      if (r_cal_cnt == CAL_LAST) r_calib <= 1'b1;
      else                       r_cal_cnt <= r_cal_cnt + CW'(1);
    end
  end

  // command FIFO (cmd + word index) and write-data FIFO, each 4 deep
  logic [2:0]        r_cq_cmd [4];
  logic [MEM_AW-1:0] r_cq_idx [4];
  logic [1:0]        r_cq_wp, r_cq_rp;
  logic [2:0]        r_cq_cnt;
  logic [DATA_W-1:0] r_dq_dat [4];
  logic [1:0]        r_dq_wp, r_dq_rp;
  logic [2:0]        r_dq_cnt;

  logic w_cq_full, w_cq_empty, w_dq_full, w_dq_empty;
  logic w_cmd_gate, w_dat_gate;
  logic w_cmd_push, w_dat_push;
  logic w_cq_pop, w_dq_pop, w_mem_we, w_rd_issue, w_bad_cmd;

  assign w_cq_full  = (r_cq_cnt == 3'd4);
  assign w_cq_empty = (r_cq_cnt == 3'd0);
  assign w_dq_full  = (r_dq_cnt == 3'd4);
  assign w_dq_empty = (r_dq_cnt == 3'd0);

`ifdef MIG_RESP_THROTTLE_EN
  logic [15:0] r_lfsr;
  logic        w_lfsr_fb;

  // Fibonacci taps 16,14,13,11
  assign w_lfsr_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

  always_ff @(posedge ui_clk) begin
    if (!rst_n)       r_lfsr <= 16'hACE1;
    else if (r_calib) r_lfsr <= {r_lfsr[14:0], w_lfsr_fb};
  end

  assign w_cmd_gate = (r_lfsr[1:0] != 2'b00);
  assign w_dat_gate = (r_lfsr[3:2] != 2'b00);
`else
  assign w_cmd_gate = 1'b1;
  assign w_dat_gate = 1'b1;
`endif

  assign ui.init_calib_complete = r_calib;
  assign ui.app_rdy             = r_calib & ~w_cq_full & w_cmd_gate;
  assign ui.app_wdf_rdy         = r_calib & ~w_dq_full & w_dat_gate;

  assign w_cmd_push = ui.app_en & ui.app_rdy;
  assign w_dat_push = ui.app_wdf_wren & ui.app_wdf_rdy;

  logic [2:0]        w_head_cmd;
  logic [MEM_AW-1:0] w_head_idx;
  assign w_head_cmd = r_cq_cmd[r_cq_rp];
  assign w_head_idx = r_cq_idx[r_cq_rp];

  // retire engine: one head per cycle; a write with no data blocks everything behind it
  always_comb begin
    w_cq_pop   = 1'b0;
    w_dq_pop   = 1'b0;
    w_mem_we   = 1'b0;
    w_rd_issue = 1'b0;
    w_bad_cmd  = 1'b0;
    if (!w_cq_empty) begin
      case (w_head_cmd)
        3'd0: begin
          if (!w_dq_empty) begin
            w_cq_pop = 1'b1;
            w_dq_pop = 1'b1;
            w_mem_we = 1'b1;
          end
        end
        3'd1: begin
          w_cq_pop   = 1'b1;
          w_rd_issue = 1'b1;
        end
        default: begin
          w_cq_pop  = 1'b1;
          w_bad_cmd = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge ui_clk) begin
    if (!rst_n) begin
      r_cq_wp  <= '0;
      r_cq_rp  <= '0;
      r_cq_cnt <= '0;
      r_dq_wp  <= '0;
      r_dq_rp  <= '0;
      r_dq_cnt <= '0;
    end else begin
      r_cq_wp  <= r_cq_wp + 2'(w_cmd_push);
      r_cq_rp  <= r_cq_rp + 2'(w_cq_pop);
      r_cq_cnt <= r_cq_cnt + 3'(w_cmd_push) - 3'(w_cq_pop);
      r_dq_wp  <= r_dq_wp + 2'(w_dat_push);
      r_dq_rp  <= r_dq_rp + 2'(w_dq_pop);
      r_dq_cnt <= r_dq_cnt + 3'(w_dat_push) - 3'(w_dq_pop);
    end
  end

  // FIFO payloads need no reset; pointers define validity
  always_ff @(posedge ui_clk) begin
    if (w_cmd_push) begin
      r_cq_cmd[r_cq_wp] <= ui.app_cmd;
      r_cq_idx[r_cq_wp] <= ui.app_addr[MEM_AW+2:3];
    end
    if (w_dat_push) begin
      r_dq_dat[r_dq_wp] <= ui.app_wdf_data;
    end
  end

  // backing store survives rst_n
  logic [DATA_W-1:0] r_mem [2**MEM_AW];
  logic [DATA_W-1:0] w_rd_word;

  assign w_rd_word = r_mem[w_head_idx];

  always_ff @(posedge ui_clk) begin
    if (w_mem_we) r_mem[w_head_idx] <= r_dq_dat[r_dq_rp];
  end

  logic r_err;

  always_ff @(posedge ui_clk) begin
    if (!rst_n)         r_err <= 1'b0;
    else if (w_bad_cmd) r_err <= 1'b1;
  end

  assign ui.err_cmd = r_err;

  // read return pipeline: stage k holds data k+1 cycles after retire
  logic [RD_LAT-1:0] r_rd_vld;
  logic [DATA_W-1:0] r_rd_dat [RD_LAT];

  always_ff @(posedge ui_clk) begin
    if (!rst_n) begin
      r_rd_vld <= '0;
      for (int i = 0; i < RD_LAT; i++) r_rd_dat[i] <= '0;
    end else begin
      r_rd_vld    <= {r_rd_vld[RD_LAT-2:0], w_rd_issue};
      r_rd_dat[0] <= w_rd_issue ? w_rd_word : '0;
      for (int i = 1; i < RD_LAT; i++) r_rd_dat[i] <= r_rd_dat[i-1];
    end
  end

  assign ui.app_rd_data       = r_rd_dat[RD_LAT-1];
  assign ui.app_rd_data_valid = r_rd_vld[RD_LAT-1];
  assign ui.app_rd_data_end   = r_rd_vld[RD_LAT-1];

  // burst-end marker and out-of-range address bits carry no function here
  logic w_unused;
  assign w_unused = &{1'b0, ui.app_wdf_end, ui.app_addr[2:0], ui.app_addr[27:MEM_AW+3]};

endmodule

// File: tb/tb_mig_ui_responder.sv
// Directed bench for mig_ui_responder: vector table of write/read pairs plus hand-built
// sequences for calibration, split command/data ordering, FIFO full, bad command and reset.
module tb_mig_ui_responder;
  localparam int DW     = 128;
  localparam int RD_LAT = 4;
  localparam int CAL    = 64;

  logic ui_clk = 1'b0;
  logic rst_n  = 1'b0;
  always #5 ui_clk = ~ui_clk;

  mig_ui_responder_if #(.DATA_W(DW)) ui ();

  mig_ui_responder #(
    .DATA_W(DW), .MEM_AW(10), .RD_LAT(RD_LAT), .CALIB_CYCLES(CAL)
  ) dut (
    .ui_clk(ui_clk),
    .rst_n (rst_n),
    .ui    (ui)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  always @(posedge ui_clk) cyc <= cyc + 1;

  logic [DW-1:0] q_dat [$];
  int            q_cyc [$];

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: timed out waiting on DUT", nm);
  endtask

  always @(negedge ui_clk) begin
    if (ui.app_rd_data_valid === 1'b1) begin
      q_dat.push_back(ui.app_rd_data);
      q_cyc.push_back(cyc);
      chk("rd_data_end", ui.app_rd_data_end, 1);
    end
  end

  task automatic step();
    @(posedge ui_clk);
    #1;
  endtask

  task automatic send_cmd(input logic [2:0] c, input logic [27:0] a, output int acc);
    bit r;
    acc = -1;
    ui.app_en = 1'b1; ui.app_cmd = c; ui.app_addr = a;
    for (int i = 0; i < 200 && acc < 0; i++) begin
      r = ui.app_rdy;
      step();
      if (r) acc = cyc;
    end
    ui.app_en = 1'b0;
    if (acc < 0) timeout("cmd_accept");
  endtask

  task automatic send_dat(input logic [DW-1:0] d, output int acc);
    bit r;
    acc = -1;
    ui.app_wdf_wren = 1'b1; ui.app_wdf_end = 1'b1; ui.app_wdf_data = d;
    for (int i = 0; i < 200 && acc < 0; i++) begin
      r = ui.app_wdf_rdy;
      step();
      if (r) acc = cyc;
    end
    ui.app_wdf_wren = 1'b0; ui.app_wdf_end = 1'b0;
    if (acc < 0) timeout("dat_accept");
  endtask

  task automatic wr_both(input logic [27:0] a, input logic [DW-1:0] d);
    bit cr, dr;
    ui.app_en = 1'b1; ui.app_cmd = 3'd0; ui.app_addr = a;
    ui.app_wdf_wren = 1'b1; ui.app_wdf_end = 1'b1; ui.app_wdf_data = d;
    for (int i = 0; i < 200 && (ui.app_en || ui.app_wdf_wren); i++) begin
      cr = ui.app_rdy;
      dr = ui.app_wdf_rdy;
      step();
      if (cr) ui.app_en = 1'b0;
      if (dr) begin ui.app_wdf_wren = 1'b0; ui.app_wdf_end = 1'b0; end
    end
    if (ui.app_en || ui.app_wdf_wren) begin
      timeout("wr_both");
      ui.app_en = 1'b0; ui.app_wdf_wren = 1'b0; ui.app_wdf_end = 1'b0;
    end
  endtask

  task automatic wait_rd(input string nm, output logic [DW-1:0] d, output int c);
    for (int i = 0; i < 40 && q_dat.size() == 0; i++) step();
    if (q_dat.size() == 0) begin
      timeout(nm);
      d = '0; c = -1000;
    end else begin
      d = q_dat.pop_front();
      c = q_cyc.pop_front();
    end
  endtask

  task automatic do_read(input string nm, input logic [27:0] a, input logic [DW-1:0] exp);
    int acc, gc;
    logic [DW-1:0] got;
    send_cmd(3'd1, a, acc);
    wait_rd(nm, got, gc);
    chk({nm, "_data"}, got, exp);
    chk({nm, "_lat"}, gc - acc, RD_LAT);
  endtask

  typedef struct {
    bit            is_wr;
    logic [27:0]   addr;
    logic [DW-1:0] dat;
    string         nm;
  } vec_t;

  vec_t tbl [11];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int a1, a2, d1, gc, n;
    bit ok;
    logic [DW-1:0] got;

    tbl[0]  = '{1'b1, 28'h40,   128'hA5A5,      "w40"};
    tbl[1]  = '{1'b0, 28'h40,   128'hA5A5,      "rd_40"};
    tbl[2]  = '{1'b1, 28'h2000, 128'h1234_5678, "w2000"};
    tbl[3]  = '{1'b0, 28'h0,    128'h1234_5678, "rd_wrap0"};
    tbl[4]  = '{1'b1, 28'h10,   128'hDEAD,      "w10"};
    tbl[5]  = '{1'b1, 28'h18,   128'hBEEF,      "w18"};
    tbl[6]  = '{1'b0, 28'h10,   128'hDEAD,      "rd_10"};
    tbl[7]  = '{1'b0, 28'h18,   128'hBEEF,      "rd_18"};
    tbl[8]  = '{1'b1, 28'h10,   128'hCAFE,      "w10b"};
    tbl[9]  = '{1'b0, 28'h10,   128'hCAFE,      "rd_10_new"};
    tbl[10] = '{1'b1, 28'h3FF8, {64'hFFFF_0000_1111_2222, 64'h3333_4444_5555_6666}, "w3ff"};

    ui.app_en = 1'b0; ui.app_cmd = 3'd0; ui.app_addr = '0;
    ui.app_wdf_wren = 1'b0; ui.app_wdf_end = 1'b0; ui.app_wdf_data = '0;

    // reset values and calibration timing
    repeat (3) step();
    chk("rst_calib", ui.init_calib_complete, 0);
    chk("rst_app_rdy", ui.app_rdy, 0);
    chk("rst_wdf_rdy", ui.app_wdf_rdy, 0);
    chk("rst_rd_valid", ui.app_rd_data_valid, 0);
    chk("rst_rd_data", ui.app_rd_data, 0);
    chk("rst_err", ui.err_cmd, 0);
    rst_n = 1'b1;
    ok = 1'b1;
    for (int i = 1; i < CAL; i++) begin
      step();
      if (ui.init_calib_complete !== 1'b0 || ui.app_rdy !== 1'b0 || ui.app_wdf_rdy !== 1'b0) ok = 1'b0;
    end
    chk("calib_early_low", ok, 1);
    step();
    chk("calib_rise", ui.init_calib_complete, 1);
    chk("calib_app_rdy", ui.app_rdy, 1);
    chk("calib_wdf_rdy", ui.app_wdf_rdy, 1);

    for (int k = 0; k < 11; k++) begin
      if (tbl[k].is_wr) wr_both(tbl[k].addr, tbl[k].dat);
      else              do_read(tbl[k].nm, tbl[k].addr, tbl[k].dat);
    end
    do_read("rd_wrap3ff", 28'h7FF8, tbl[10].dat);

    // command first, data three cycles later; the read queued behind must wait
    send_cmd(3'd0, 28'h8, a1);
    send_cmd(3'd1, 28'h8, a2);
    repeat (3) step();
    chk("cf_no_early_rd", q_dat.size(), 0);
    send_dat(128'h77, d1);
    wait_rd("cf_rd", got, gc);
    chk("cf_rd_data", got, 128'h77);
    chk("cf_rd_lat", gc - d1, RD_LAT + 1);

    // data first: fill the data FIFO, then drain with commands
    ui.app_wdf_wren = 1'b1; ui.app_wdf_end = 1'b1;
    for (int k = 0; k < 4; k++) begin
      ui.app_wdf_data = 128'hD0 + DW'(k);
      chk("df_wdf_rdy_fill", ui.app_wdf_rdy, 1);
      step();
    end
    ui.app_wdf_data = 128'hEE;
    chk("df_wdf_rdy_full", ui.app_wdf_rdy, 0);
    chk("df_app_rdy_free", ui.app_rdy, 1);
    ui.app_wdf_wren = 1'b0; ui.app_wdf_end = 1'b0;
    for (int k = 0; k < 4; k++) send_cmd(3'd0, 28'h100 + 28'(8 * k), a1);
    repeat (2) step();
    chk("df_wdf_rdy_back", ui.app_wdf_rdy, 1);
    for (int k = 0; k < 4; k++) do_read("df_rd", 28'h100 + 28'(8 * k), 128'hD0 + DW'(k));

    // unsupported command is a sticky-error no-op
    send_cmd(3'd5, 28'h40, a1);
    repeat (RD_LAT + 4) step();
    chk("bad_err_set", ui.err_cmd, 1);
    chk("bad_no_rd", q_dat.size(), 0);
    do_read("bad_then_rd", 28'h40, 128'hA5A5);
    chk("bad_err_sticky", ui.err_cmd, 1);

    // reset mid-operation discards pending data and in-flight reads
    send_dat(128'h99, d1);
    send_cmd(3'd1, 28'h40, a1);
    rst_n = 1'b0;
    repeat (2) step();
    chk("mid_rst_calib", ui.init_calib_complete, 0);
    chk("mid_rst_app_rdy", ui.app_rdy, 0);
    chk("mid_rst_valid", ui.app_rd_data_valid, 0);
    chk("mid_rst_err", ui.err_cmd, 0);
    rst_n = 1'b1;
    n = 0;
    while (ui.init_calib_complete !== 1'b1 && n < 200) begin
      step();
      n++;
    end
    chk("recal_cycles", n, CAL);
    chk("mid_rst_no_rd", q_dat.size(), 0);
    send_cmd(3'd0, 28'h40, a1);
    repeat (3) step();
    chk("mid_rst_dq_empty", q_dat.size(), 0);
    send_dat(128'hBB, d1);
    do_read("post_rst_rd", 28'h40, 128'hBB);

    repeat (5) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mig_ui_responder.md
MIG_UI_RESPONDER -- requirements
Module: mig_ui_responder

Interface
REQ-001 Parameter DATA_W, default 128, width of the app write and read data words.
REQ-002 Parameter MEM_AW, default 10, log2 of the backing-store depth in words.
REQ-003 Parameter RD_LAT, default 4, range 2..15, cycles from read-command retire to app_rd_data_valid.
REQ-004 Parameter CALIB_CYCLES, default 64, cycles after reset release before init_calib_complete rises.
REQ-005 The block SHALL have one clock and a synchronous, active-low reset.
REQ-006 ui_clk  in  1  sole clock; all logic on its rising edge.
REQ-007 rst_n  in  1  synchronous reset, active low.
REQ-008 init_calib_complete  out  1  calibration-done emulation.
REQ-009 app_rdy  out  1  command accepted this cycle when high together with app_en.
REQ-010 app_wdf_rdy  out  1  write data accepted this cycle when high together with app_wdf_wren.
REQ-011 app_en  in  1  command valid.
REQ-012 app_cmd  in  3  3'd0 write, 3'd1 read, any other value unsupported.
REQ-013 app_addr  in  28  byte-group address; consecutive bursts step by 8.
REQ-014 app_wdf_wren  in  1  write data valid.
REQ-015 app_wdf_end  in  1  last beat of burst; ignored functionally, each wren is one full burst.
REQ-016 app_wdf_data  in  DATA_W  write data.
REQ-017 app_rd_data  out  DATA_W  read data.
REQ-018 app_rd_data_valid  out  1  read data valid, one cycle per read command.
REQ-019 app_rd_data_end  out  1  equal to app_rd_data_valid.
REQ-020 err_cmd  out  1  sticky flag, set on acceptance of an unsupported app_cmd.

Function
REQ-021 Word index SHALL be app_addr[MEM_AW+2:3]; higher address bits are ignored, so addresses wrap modulo the store depth.
REQ-022 A calibration counter SHALL count from reset release; init_calib_complete SHALL rise on cycle CALIB_CYCLES and stay high until reset.
REQ-023 Before init_calib_complete, app_rdy and app_wdf_rdy SHALL be 0.
REQ-024 Accepted commands SHALL enter a 4-entry command FIFO holding cmd and word index; app_rdy SHALL be 0 when that FIFO is full.
REQ-025 Accepted write data SHALL enter a 4-entry data FIFO, independent of the command FIFO; app_wdf_rdy SHALL be 0 when that FIFO is full.
REQ-026 Data before its command and command before its data SHALL both be legal; pairing SHALL be strictly in order.
REQ-027 Retire engine: at most one command per cycle, taken from the FIFO head.
REQ-028 A write head SHALL retire only when the data FIFO is non-empty; retiring pops both FIFOs and writes the store in that same cycle.
REQ-029 A write head with an empty data FIFO SHALL stall the command FIFO; later reads do not bypass it.
REQ-030 A read head SHALL retire unconditionally; it reads the store and enters a RD_LAT-deep valid/data pipeline.
REQ-031 app_rd_data_valid SHALL assert exactly RD_LAT cycles after the read retires; there is no read-data backpressure.
REQ-032 Read-after-write to the same index SHALL return the new data when the write retired in an earlier cycle.
REQ-033 An unsupported command SHALL retire as a no-op, pop only the command FIFO, and set err_cmd.
REQ-034 A FIFO push and pop in the same cycle when full SHALL be allowed only through the not-full rdy rule; when empty, push and pop SHALL pass the entry with no loss.
REQ-035 Store contents SHALL be undefined after power-up and SHALL be kept across rst_n.

Reset
REQ-036 While rst_n=0 at a clock edge the following SHALL be cleared: init_calib_complete, app_rdy, app_wdf_rdy, app_rd_data_valid, app_rd_data_end, err_cmd, the calibration counter, both FIFOs and the read pipeline.
REQ-037 app_rd_data SHALL reset to 0.
REQ-038 Reset asserted mid-operation SHALL discard pending commands, pending data and in-flight reads; calibration SHALL restart.

Configuration
REQ-039 Macro MIG_RESP_THROTTLE_EN SHALL select ready throttling.
REQ-040 With MIG_RESP_THROTTLE_EN defined, a 16-bit LFSR (seed 16'hACE1, taps 16,14,13,11, advancing every cycle after calibration) SHALL gate the ready outputs.
REQ-041 Under throttling, app_rdy SHALL be forced 0 when LFSR[1:0]==2'b00 and app_wdf_rdy SHALL be forced 0 when LFSR[3:2]==2'b00.
REQ-042 Without MIG_RESP_THROTTLE_EN, the ready outputs SHALL depend only on calibration and FIFO fullness.

Verification
REQ-043 Reset then idle -> init_calib_complete rises exactly 64 cycles after rst_n goes high; app_rdy stays 0 until then.
REQ-044 Write, same cycle: app_en+app_wdf_wren, addr 28'h40, data 128'hA5A5 -> read addr 28'h40 returns valid 4 cycles after retire, data 128'hA5A5.
REQ-045 Write, command-first: write command at 28'h8, data 3 cycles later; then read 28'h8 -> read returns that data, not stale contents, and only after the write retires.
REQ-046 Write, data-first: 4 data beats with no command -> app_wdf_rdy drops to 0 on the 5th cycle; 4 write commands then drain both FIFOs, with rdy recovering.
REQ-047 Unsupported command: app_cmd=3'd5 accepted -> err_cmd=1 and stays 1; no read data; a following read executes normally.
REQ-048 Address wrap: write 28'h2000 (MEM_AW=10), then read 28'h0 -> same data returned.
